// File: rtl/sqw_pkg.sv
// Shared definitions for the square-wave generator/meter family.
//   meas_state_t  : meter FSM state encoding (ACQUIRE, MEAS_LOW, MEAS_HIGH)
//   SQW_TICK_DIV  : default clock cycles per duration unit
//   SQW_W         : default width of duration values
package sqw_pkg;

    typedef enum logic [1:0] {
        ACQUIRE   = 2'd0,
        MEAS_LOW  = 2'd1,
        MEAS_HIGH = 2'd2
    } meas_state_t;

    localparam int unsigned SQW_TICK_DIV = 10;
    localparam int unsigned SQW_W        = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, plus a third flop holding
// the previous synchronized level so edges can be decoded.
//   clk   : sampling clock
//   reset : asynchronous active-low reset (all flops cleared to 0)
//   din   : asynchronous input level
//   rise  : synchronized level went 0 -> 1 (valid for one cycle)
//   fall  : synchronized level went 1 -> 0 (valid for one cycle)
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            // stage 0: first capture, may be metastable
            sync_p0 <= din;
            // stage 1: settled synchronized level
            sync_p1 <= sync_p0;
            // stage 2: previous synchronized level for edge decode
            prev_p2 <= sync_p1;
        end
    end

    assign rise =  sync_p1 & ~prev_p2;
    assign fall = ~sync_p1 &  prev_p2;

endmodule

// File: rtl/square_wave_meter.sv
// Measures the low and high durations of an asynchronous square wave in
// units of TICK_DIV clock cycles, rounded to nearest (minimum 1).
//   clk         : single clock, all state on the rising edge
//   reset       : asynchronous active-low reset
//   square_wave : asynchronous waveform under measurement
//   m_meas      : last measured low duration (W bits)
//   n_meas      : last measured high duration (W bits)
//   valid       : one-cycle pulse when a fresh full period is available
//   locked      : both a low and a high phase measured since last acquire
//   stuck       : current level has outlasted the measurable range
module square_wave_meter
    import sqw_pkg::*;
#(
    parameter int unsigned TICK_DIV = SQW_TICK_DIV,
    parameter int unsigned W        = SQW_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         square_wave,
    output logic [W-1:0] m_meas,
    output logic [W-1:0] n_meas,
    output logic         valid,
    output logic         locked,
    output logic         stuck
);

    localparam int unsigned MAXV  = (1 << W) - 1;
    localparam int unsigned LIMIT = MAXV * TICK_DIV + TICK_DIV / 2;
    // The counter holds (phase length - 2) on a cycle with no edge, so the
    // phase reaches LIMIT synchronized cycles when the counter reads LIMIT-2.
    // Firing there also means any measured phase is at most LIMIT-1 long,
    // which always rounds to <= MAXV.
    localparam int unsigned TO_E  = LIMIT - 2;
    localparam int unsigned TO_U  = TO_E / TICK_DIV;
    localparam int unsigned TO_P  = TO_E % TICK_DIV;
    // With L = units*TICK_DIV + pre + 1, rounding adds one unit when
    // pre + 1 >= TICK_DIV - TICK_DIV/2.
    localparam int unsigned THR   = TICK_DIV - TICK_DIV / 2 - 1;
    localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned WX    = W + 1;

    localparam logic [W-1:0]  MAXV_V   = W'(MAXV);
    localparam logic [W-1:0]  TO_U_V   = W'(TO_U);
    localparam logic [PW-1:0] TO_P_V   = PW'(TO_P);
    localparam logic [PW-1:0] THR_V    = PW'(THR);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    meas_state_t   state;
    logic [PW-1:0] pre;
    logic [W-1:0]  units;
    logic          got_m;
    logic          got_n;
    logic          rise;
    logic          fall;
    logic          cnt_full;
    logic          timeout_hit;
    logic [W-1:0]  d_now;

    // Round-to-nearest unit count, clamped to 1..MAXV.
    function automatic logic [W-1:0] round_units(input logic [W-1:0]  u,
                                                 input logic [PW-1:0] p);
        logic [W:0] d;
        d = {1'b0, u};
        if (p >= THR_V)
            d = d + WX'(1);
        if (d == '0)
            d = WX'(1);
        if (d > WX'(MAXV))
            d = WX'(MAXV);
        return d[W-1:0];
    endfunction

    sync_edge_detect u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (square_wave),
        .rise  (rise),
        .fall  (fall)
    );

    assign d_now       = round_units(units, pre);
    assign cnt_full    = (units == MAXV_V) && (pre == PRE_LAST);
    assign timeout_hit = (units == TO_U_V) && (pre == TO_P_V);

    // stage 3: measurement FSM and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ACQUIRE;
            pre    <= '0;
            units  <= '0;
            got_m  <= 1'b0;
            got_n  <= 1'b0;
            m_meas <= '0;
            n_meas <= '0;
            valid  <= 1'b0;
            locked <= 1'b0;
            stuck  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (rise || fall) begin
                pre   <= '0;
                units <= '0;
                stuck <= 1'b0;
                unique case (state)
                    ACQUIRE: begin
                        // partial phase before the first edge is discarded
                        state <= rise ? MEAS_HIGH : MEAS_LOW;
                    end
                    MEAS_LOW: begin
                        if (rise) begin
                            m_meas <= d_now;
                            got_m  <= 1'b1;
                            if (got_n)
                                locked <= 1'b1;
                            state <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH: begin
                        if (fall) begin
                            n_meas <= d_now;
                            got_n  <= 1'b1;
                            // a fall completes a period once a low was seen
                            if (got_m) begin
                                locked <= 1'b1;
                                valid  <= 1'b1;
                            end
                            state <= MEAS_LOW;
                        end
                    end
                    default: state <= ACQUIRE;
                endcase
            end else begin
                if (!cnt_full) begin
                    if (pre == PRE_LAST) begin
                        pre   <= '0;
                        units <= units + W'(1);
                    end else begin
                        pre <= pre + PW'(1);
                    end
                end
                if ((state != ACQUIRE) && timeout_hit) begin
                    if (state == MEAS_LOW)
                        m_meas <= '0;
                    else
                        n_meas <= '0;
                    stuck  <= 1'b1;
                    locked <= 1'b0;
                    valid  <= 1'b1;
                    got_m  <= 1'b0;
                    got_n  <= 1'b0;
                    state  <= ACQUIRE;
                end
            end
        end
    end

endmodule
